// File: rtl/regvec_pkg.sv
`default_nettype none
// ============================================================================
// Module   : regvec_pkg
// Purpose  : Opcodes, field-width functions and instruction-field extraction
//            helpers shared by the register-vector interpreter.
// Revision : 1.0
// ============================================================================
package regvec_pkg;

    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,
        OP_MOV  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_LNOT = 4'd5,
        OP_BNOT = 4'd6,
        OP_ADD  = 4'd7,
        OP_SUB  = 4'd8,
        OP_MUL  = 4'd9
    } op_e;

    // Widest instruction word the helpers accept; callers zero-extend into it.
    localparam int MAX_IW = 32;

    function automatic int ri_width(input int nreg);
        return $clog2(nreg);
    endfunction

    function automatic int iw_width(input int nreg);
        return 4 + ri_width(nreg) + 2 * (ri_width(nreg) + 1);
    endfunction

    function automatic logic [3:0] instr_op(input logic [MAX_IW-1:0] instr, input int nreg);
        return 4'(instr >> (iw_width(nreg) - 4));
    endfunction

    function automatic logic [7:0] instr_dst(input logic [MAX_IW-1:0] instr, input int nreg);
        return 8'(instr >> (2 * (ri_width(nreg) + 1))) & 8'((1 << ri_width(nreg)) - 1);
    endfunction

    function automatic logic [7:0] instr_sa(input logic [MAX_IW-1:0] instr, input int nreg);
        return 8'(instr >> (ri_width(nreg) + 1)) & 8'((1 << (ri_width(nreg) + 1)) - 1);
    endfunction

    function automatic logic [7:0] instr_sb(input logic [MAX_IW-1:0] instr, input int nreg);
        return 8'(instr) & 8'((1 << (ri_width(nreg) + 1)) - 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/regvec_interp_if.sv
`default_nettype none
// ============================================================================
// Module   : regvec_interp_if
// Purpose  : Program-load, input-vector and result handshake bundle.
// Revision : 1.0
// ============================================================================
interface regvec_interp_if #(
    parameter int W          = 16,
    parameter int NREG       = 4,
    parameter int PROG_DEPTH = 16
);
    import regvec_pkg::*;

    localparam int AW = $clog2(PROG_DEPTH);
    localparam int IW = iw_width(NREG);

    logic                prog_we;
    logic [AW-1:0]       prog_addr;
    logic [IW-1:0]       prog_wdata;
    logic [AW:0]         prog_len;
    logic                in_valid;
    logic                in_ready;
    logic [NREG*W-1:0]   in_data;
    logic                out_valid;
    logic                out_ready;
    logic [NREG*W-1:0]   out_data;
    logic                busy;

    modport master (
        output prog_we, prog_addr, prog_wdata, prog_len,
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  prog_we, prog_addr, prog_wdata, prog_len,
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, busy
    );

endinterface
`default_nettype wire

// File: rtl/regvec_alu.sv
`default_nettype none
// ============================================================================
// Module   : regvec_alu
// Purpose  : Combinational W-bit operation unit for the interpreter.
// Revision : 1.0
// ============================================================================
module regvec_alu
    import regvec_pkg::*;
#(
    parameter int W = 16
) (
    input  logic [3:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y
);

    always_comb begin
        y = '0;
        case (op_e'(op))
            OP_MOV:  y = a;
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_LNOT: y = {{(W-1){1'b0}}, (a == '0)};
            OP_BNOT: y = ~a;
            OP_ADD:  y = a + b;
            OP_SUB:  y = a - b;
            OP_MUL:  y = a * b;
            default: y = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/regvec_interp.sv
`default_nettype none
// ============================================================================
// Module   : regvec_interp
// Purpose  : Programmable straight-line register-transfer interpreter over an
//            NREG-entry register file; one instruction per cycle.
// Revision : 1.0
// ============================================================================
module regvec_interp
    import regvec_pkg::*;
#(
    parameter int W          = 16,
    parameter int NREG       = 4,
    parameter int PROG_DEPTH = 16
) (
    input  logic           clk,
    input  logic           rst,
    regvec_interp_if.slave bus
);

    localparam int IW = iw_width(NREG);
    localparam int AW = $clog2(PROG_DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e              r_state;
    state_e              w_next;
    logic [W-1:0]        r_regs [NREG];
    logic [W-1:0]        r_inc  [NREG];
    logic [IW-1:0]       r_imem [PROG_DEPTH];
    logic [AW-1:0]       r_pc;
    logic [LW-1:0]       r_len;

    logic                w_accept;
    logic                w_last;
    logic                w_wr_en;
    logic [LW-1:0]       w_len_clamped;
    logic [MAX_IW-1:0]   w_instr;
    logic [3:0]          w_op;
    logic [7:0]          w_dst;
    logic [7:0]          w_sa;
    logic [7:0]          w_sb;
    logic [W-1:0]        w_a;
    logic [W-1:0]        w_b;
    logic [W-1:0]        w_alu;

    assign w_accept      = bus.in_valid && (r_state == S_IDLE);
    assign w_len_clamped = (bus.prog_len > LW'(PROG_DEPTH)) ? LW'(PROG_DEPTH) : bus.prog_len;
    assign w_last        = ({1'b0, r_pc} == (r_len - LW'(1)));

    assign w_instr = {{(MAX_IW-IW){1'b0}}, r_imem[r_pc]};
    assign w_op    = instr_op(w_instr, NREG);
    assign w_dst   = instr_dst(w_instr, NREG);
    assign w_sa    = instr_sa(w_instr, NREG);
    assign w_sb    = instr_sb(w_instr, NREG);
    assign w_wr_en = (w_op != OP_NOP) && (w_op <= OP_MUL);

    // Indices below NREG read the live register file, the rest read the
    // input copies latched at accept.
    always_comb begin
        w_a = '0;
        w_b = '0;
        for (int k = 0; k < NREG; k++) begin
            if (w_sa == 8'(k))        w_a = r_regs[k];
            if (w_sa == 8'(k + NREG)) w_a = r_inc[k];
            if (w_sb == 8'(k))        w_b = r_regs[k];
            if (w_sb == 8'(k + NREG)) w_b = r_inc[k];
        end
    end

    regvec_alu #(.W(W)) u_alu (
        .op (w_op),
        .a  (w_a),
        .b  (w_b),
        .y  (w_alu)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = (w_len_clamped == '0) ? S_DONE : S_RUN;
            S_RUN:   if (w_last) w_next = S_DONE;
            S_DONE:  if (bus.out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // A write in the accept cycle lands before the first fetch, so it is
    // visible to the program being started.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < PROG_DEPTH; i++) r_imem[i] <= '0;
        end else if (r_state == S_IDLE && bus.prog_we) begin
            r_imem[bus.prog_addr] <= bus.prog_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc  <= '0;
            r_len <= '0;
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
                r_inc[i]  <= '0;
            end
        end else if (w_accept) begin
            r_pc  <= '0;
            r_len <= w_len_clamped;
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= bus.in_data[i*W +: W];
                r_inc[i]  <= bus.in_data[i*W +: W];
            end
        end else if (r_state == S_RUN) begin
            r_pc <= r_pc + AW'(1);
            for (int i = 0; i < NREG; i++) begin
                if (w_wr_en && (w_dst == 8'(i))) r_regs[i] <= w_alu;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_out
            assign bus.out_data[gi*W +: W] = r_regs[gi];
        end
    endgenerate

    assign bus.in_ready  = (r_state == S_IDLE) && !rst;
    assign bus.out_valid = (r_state == S_DONE) && !rst;
    assign bus.busy      = ((r_state == S_RUN) || (r_state == S_DONE)) && !rst;

endmodule
`default_nettype wire

// File: tb/tb_regvec_interp.sv
`default_nettype none
// ============================================================================
// Module   : tb_regvec_interp
// Purpose  : Self-checking bench for regvec_interp (W=16, NREG=4, depth 16).
// Revision : 1.0
// ============================================================================
module tb_regvec_interp;
    import regvec_pkg::*;

    localparam int W    = 16;
    localparam int NREG = 4;
    localparam int PD   = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    regvec_interp_if #(.W(W), .NREG(NREG), .PROG_DEPTH(PD)) bus();

    regvec_interp #(.W(W), .NREG(NREG), .PROG_DEPTH(PD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [PD*12-1:0] prog;
        int               len;
        logic [63:0]      din;
        logic [63:0]      exp;
    } vec_t;

    vec_t        vecs [5];
    logic [63:0] sb_q [$];
    int          n_chk  = 0;
    int          n_fail = 0;

    function automatic logic [11:0] ins(input logic [3:0] op, input int dst, input int sa, input int sb);
        return {op, 2'(dst), 3'(sa), 3'(sb)};
    endfunction

    function automatic logic [63:0] pk(input logic [15:0] r0, r1, r2, r3);
        return {r3, r2, r1, r0};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [PD*12-1:0] prog, input int n);
        for (int i = 0; i < n; i++) begin
            bus.prog_we    = 1'b1;
            bus.prog_addr  = 4'(i);
            bus.prog_wdata = prog[i*12 +: 12];
            tick();
        end
        bus.prog_we = 1'b0;
    endtask

    // inject > 0: attempt an instruction overwrite at the executing address in that RUN cycle
    task automatic run_vec(input vec_t v, input int hold, input int inject, input bit do_load);
        int          eff;
        int          cyc;
        logic [63:0] e;
        eff = (v.len > PD) ? PD : v.len;
        if (do_load) load(v.prog, eff);
        chk("in_ready_idle", 64'(bus.in_ready), 64'd1);
        bus.prog_len = 5'(v.len);
        bus.in_data  = v.din;
        bus.in_valid = 1'b1;
        sb_q.push_back(v.exp);
        tick();
        bus.in_valid = 1'b0;
        cyc = 1;
        while (!bus.out_valid && cyc < 40) begin
            if (cyc == inject) begin
                bus.prog_we    = 1'b1;
                bus.prog_addr  = 4'(cyc - 1);
                bus.prog_wdata = ins(OP_MOV, 1, 5, 0);
            end else begin
                bus.prog_we = 1'b0;
            end
            tick();
            cyc++;
        end
        bus.prog_we = 1'b0;
        chk("latency", 64'(cyc), 64'(eff + 1));
        e = sb_q.pop_front();
        chk("out_data", bus.out_data, e);
        for (int h = 0; h < hold; h++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = ~v.din;
            tick();
            chk("hold_out_data", bus.out_data, e);
            chk("hold_flags", 64'({bus.in_ready, bus.out_valid}), 64'b01);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("idle_after_done", 64'({bus.in_ready, bus.out_valid, bus.busy}), 64'b100);
    endtask

    initial begin
        vecs[0].prog = (PD*12)'({ins(OP_LNOT, 0, 6, 0), ins(OP_XOR, 0, 0, 6), ins(OP_XOR, 3, 3, 6),
                                 ins(OP_LNOT, 1, 4, 0), ins(OP_AND, 3, 3, 0)});
        vecs[0].len  = 5;
        vecs[0].din  = pk(16'h0005, 16'h1234, 16'h0003, 16'h00FF);
        vecs[0].exp  = pk(16'h0000, 16'h0000, 16'h0003, 16'h0006);

        vecs[1].prog = '0;
        vecs[1].len  = 0;
        vecs[1].din  = pk(16'd1, 16'd2, 16'd3, 16'd4);
        vecs[1].exp  = pk(16'd1, 16'd2, 16'd3, 16'd4);

        vecs[2].prog = (PD*12)'({ins(OP_MOV, 3, 4, 0), ins(OP_BNOT, 2, 5, 0), ins(OP_SUB, 1, 6, 7),
                                 ins(OP_ADD, 0, 4, 5)});
        vecs[2].len  = 4;
        vecs[2].din  = pk(16'hFFFF, 16'h0002, 16'h0000, 16'h0001);
        vecs[2].exp  = pk(16'h0001, 16'hFFFF, 16'hFFFD, 16'hFFFF);

        vecs[3].prog = (PD*12)'({ins(OP_XOR, 2, 2, 3), ins(4'd12, 3, 4, 4), ins(OP_OR, 2, 4, 5),
                                 ins(OP_BNOT, 1, 5, 0), ins(OP_MUL, 0, 4, 4)});
        vecs[3].len  = 5;
        vecs[3].din  = pk(16'h0100, 16'h00F0, 16'h0000, 16'h7777);
        vecs[3].exp  = pk(16'h0000, 16'hFF0F, 16'h7687, 16'h7777);

        vecs[4].prog = {PD{ins(OP_ADD, 0, 0, 5)}};
        vecs[4].len  = 31;
        vecs[4].din  = pk(16'h0000, 16'h0001, 16'h0000, 16'h0000);
        vecs[4].exp  = pk(16'h0010, 16'h0001, 16'h0000, 16'h0000);

        rst            = 1'b1;
        bus.prog_we    = 1'b0;
        bus.prog_addr  = '0;
        bus.prog_wdata = '0;
        bus.prog_len   = '0;
        bus.in_valid   = 1'b0;
        bus.in_data    = '0;
        bus.out_ready  = 1'b0;
        tick();
        tick();
        chk("reset_flags", 64'({bus.in_ready, bus.out_valid, bus.busy}), 64'b000);
        rst = 1'b0;
        tick();
        chk("post_reset_flags", 64'({bus.in_ready, bus.out_valid, bus.busy}), 64'b100);
        chk("post_reset_data", bus.out_data, 64'd0);

        for (int i = 0; i < 5; i++) run_vec(vecs[i], 0, 0, 1'b1);

        // Result backpressure with a competing input offer.
        run_vec(vecs[0], 3, 0, 1'b1);

        // Program write while running must be dropped; rerun without reloading.
        run_vec(vecs[0], 0, 2, 1'b1);
        run_vec(vecs[0], 0, 0, 1'b0);

        // Reset while pc=2 aborts with no result.
        load(vecs[0].prog, 5);
        bus.prog_len = 5'd5;
        bus.in_data  = vecs[0].din;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        chk("busy_mid_run", 64'(bus.busy), 64'd1);
        rst = 1'b1;
        #1;
        chk("rst_flags", 64'({bus.in_ready, bus.out_valid, bus.busy}), 64'b000);
        tick();
        rst = 1'b0;
        #1;
        chk("abort_flags", 64'({bus.in_ready, bus.out_valid, bus.busy}), 64'b100);
        chk("abort_data", bus.out_data, 64'd0);
        run_vec(vecs[0], 0, 0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/regvec_interp.md
# regvec_interp

Sequential register-vector interpreter: accepts a vector of NREG input words, executes a loaded straight-line program of register-transfer operations (one per cycle) over an NREG-entry register file, then presents the final register file as output. It is the parametrised, programmable successor to the fixed combinational evolved-individual modules. It sits between the fitness-evaluation stimulus driver and the result checker, so one netlist can evaluate any individual without resynthesis.

## Interface
- W, 16, datapath word width
- NREG, 4, register count; also input and output vector length (power of 2, ≥2)
- PROG_DEPTH, 16, instruction memory depth (power of 2)
- clk  in  1  clock
- rst  in  1  reset; synchronous and active-high; one clock
- prog_we  in  1  instruction write strobe; honoured only in IDLE
- prog_addr  in  $clog2(PROG_DEPTH)  instruction write address
- prog_wdata  in  IW  instruction word; IW = 4 + RI + 2*(RI+1), RI = $clog2(NREG)
- prog_len  in  $clog2(PROG_DEPTH)+1  instructions to run; sampled at accept; values > PROG_DEPTH clamp to PROG_DEPTH
- in_valid  in  1  input vector valid
- in_ready  out  1  high only in IDLE
- in_data  in  NREG*W  word i at [i*W +: W]
- out_valid  out  1  high only in DONE
- out_ready  in  1  consumer accepts result
- out_data  out  NREG*W  register r[i] at [i*W +: W]
- busy  out  1  high in RUN or DONE

## Operation
- Instruction fields, MSB→LSB: op[3:0], dst[RI-1:0], sa[RI:0], sb[RI:0].
- Operand index k < NREG selects r[k] (current value); k ≥ NREG selects latched input copy in[k−NREG] (never modified during RUN).
- Opcodes: 0 NOP; 1 MOV dst=A; 2 AND; 3 OR; 4 XOR; 5 LNOT dst=(A==0)?1:0; 6 BNOT dst=~A; 7 ADD; 8 SUB; 9 MUL; 10–15 NOP. A=operand sa, B=operand sb.
- Arithmetic: ADD/SUB/MUL compute modulo 2^W (low W bits kept, carries/high product discarded). LNOT result is zero-extended 1.
- FSM IDLE → RUN → DONE → IDLE.
  - IDLE: in_ready=1. On in_valid&&in_ready: r[i] and input copy in[i] ← in_data word i; pc←0; latch clamped prog_len as L; go RUN, or straight to DONE if L==0.
  - RUN: execute imem[pc], write r[dst]; pc++; after executing pc==L−1 go DONE. in_valid ignored.
  - DONE: out_valid=1, out_data=r (stable while waiting). On out_ready go IDLE. Register file retains its value until next accept.
- prog_we outside IDLE: ignored. prog_we and accept in the same IDLE cycle: write takes effect and is visible to the program being started.
- Reset: state IDLE, pc 0, all r and input copies 0, imem cleared to 0 (NOP), L 0. During rst high: in_ready=0, out_valid=0, busy=0. Reset mid-RUN/DONE aborts with no output.

## Timing
- Accept in cycle 0 → out_valid first high in cycle L+1 (L=0: cycle 1).
- One instruction per cycle; result of instruction n visible to instruction n+1.
- Back-to-back: out_ready high in DONE cycle t → in_ready high in cycle t+1.
- All outputs registered-state decodes; no combinational path from in_valid/out_ready to in_ready/out_valid.

## Structure
- Package regvec_pkg: opcode enum (OP_NOP..OP_MUL), field-width functions for RI and IW, instruction-field extraction helpers.
- Sub-module regvec_alu: combinational (op, A, B) → W-bit result, parametrised on W; instantiated once.
- Top holds FSM, pc, register file, input copies, instruction memory.

## Test plan
- W=16, NREG=4; program {AND r3,r3,r0; LNOT r1,in0; XOR r3,r3,in2; XOR r0,r0,in2; LNOT r0,in2}, L=5; in=(a0..b1 as 0x0005,0x1234,0x0003,0x00FF) → out_valid in cycle 6, out = r0 0x0000, r1 0x0000, r2 0x0003, r3 0x0006.
- L=0, in=(1,2,3,4) → out_valid in cycle 1, out=(1,2,3,4).
- ADD 0xFFFF+0x0002 → 0x0001; SUB 0x0000−0x0001 → 0xFFFF; MUL 0x0100×0x0100 → 0x0000; BNOT 0x00F0 → 0xFF0F.
- out_ready low 3 cycles in DONE with in_valid high → out_data stable, in_ready 0, no new accept; release → IDLE next cycle.
- prog_we during RUN to the executing address → ignored; result matches original program.
- rst asserted mid-RUN (pc=2) → next cycle IDLE, all outputs 0/ready; rerun gives correct result.
